// File: rtl/fifo_pkg.sv
// Shared constants and word type for the single-clock FIFO.
package fifo_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  typedef logic [DEF_DATA_W-1:0] word_t;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; the FIFO never exposes an unwritten entry.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Store the accepted write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo.sv
// Single-clock FIFO: pointers, occupancy count, status flags and the
// registered read-data output. Storage lives in fifo_mem.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] rdata;
  logic              do_wr, do_rd;

  // Full gates writes even when a read is requested in the same cycle,
  // so a full FIFO never writes through.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // Flags decode straight from the registered count.
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Pointer advance; natural ADDR_W-bit rollover gives modulo-DEPTH wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy: only a lone write or a lone read moves it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Read data register; only loads on an accepted read, so it never
  // picks up an unwritten entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      data_out <= '0;
    else if (do_rd) data_out <= rdata;
  end
endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: queue-based reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full, empty;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  logic [7:0] q[$];
  logic [7:0] m_dout;

  fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue following the accept rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_dout <= 8'h00;
    end else begin
      automatic bit w = wr_en && (q.size() < DEPTH);
      automatic bit r = rd_en && (q.size() > 0);
      if (r) m_dout <= q.pop_front();
      if (w) q.push_back(data_in);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_data_out", {24'b0, data_out}, {24'b0, m_dout});
      check("mdl_empty", {31'b0, empty}, {31'b0, q.size() == 0});
      check("mdl_full",  {31'b0, full},  {31'b0, q.size() == DEPTH});
    end
  end

  // Drive one cycle of inputs at the falling edge, return at the next one.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; wr_en = 0; rd_en = 0; data_in = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1;

    // 1: async reset with 3 words stored
    step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33);
    step(0, 1, 8'h00);
    check("pre_rst_dout", {24'b0, data_out}, 32'h11);
    wr_en = 0; rd_en = 0;
    #2 reset = 1'b1;
    #1;
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full",  {31'b0, full},  32'd0);
    check("rst_dout",  {24'b0, data_out}, 32'h00);
    #1 reset = 1'b0;
    @(negedge clk);
    step(0, 1, 8'h00);
    check("rst_rd_ign_dout",  {24'b0, data_out}, 32'h00);
    check("rst_rd_ign_empty", {31'b0, empty}, 32'd1);

    // 2: basic order
    step(1, 0, 8'hA5);
    step(1, 0, 8'h3C);
    step(0, 1, 8'h00);
    check("ord_rd1", {24'b0, data_out}, 32'hA5);
    step(0, 1, 8'h00);
    check("ord_rd2", {24'b0, data_out}, 32'h3C);
    check("ord_empty", {31'b0, empty}, 32'd1);

    // 3: refill
    step(1, 0, 8'hFF);
    check("refill_empty0", {31'b0, empty}, 32'd0);
    step(0, 1, 8'h00);
    check("refill_dout", {24'b0, data_out}, 32'hFF);
    check("refill_empty1", {31'b0, empty}, 32'd1);

    // 4: fill and overflow
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("fill_not_full", {31'b0, full}, 32'd0);
      step(1, 0, 8'(i));
    end
    check("fill_full", {31'b0, full}, 32'd1);
    step(1, 1, 8'hEE);  // full: write dropped, read still pops word 0
    check("ovf_rd0", {24'b0, data_out}, 32'h00);
    check("ovf_full_drop", {31'b0, full}, 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      step(0, 1, 8'h00);
      check("drain", {24'b0, data_out}, i);
    end
    check("drain_empty", {31'b0, empty}, 32'd1);

    // 5: underflow, then simultaneous read/write with wrap
    step(0, 1, 8'h00);
    check("uflow_dout",  {24'b0, data_out}, 32'h0F);
    check("uflow_empty", {31'b0, empty}, 32'd1);
    step(1, 1, 8'h4A);  // empty: only the write happens
    check("wr_empty_nobypass_dout", {24'b0, data_out}, 32'h0F);
    check("wr_empty_nobypass_empty", {31'b0, empty}, 32'd0);
    step(0, 1, 8'h00);
    check("wr_empty_next", {24'b0, data_out}, 32'h4A);
    for (int i = 0; i < 5; i++) step(1, 0, 8'h50 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 8'h60 + 8'(i));
      check("simul_dout", {24'b0, data_out}, (i < 5) ? (32'h50 + i) : (32'h60 + i - 5));
      check("simul_empty", {31'b0, empty}, 32'd0);
      check("simul_full",  {31'b0, full},  32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h00);
      check("simul_tail", {24'b0, data_out}, 32'h6F + i);
    end
    check("final_empty", {31'b0, empty}, 32'd1);

    wr_en = 0; rd_en = 0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
